// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: address/lane generation, fault screening,
// memory handshake with timeout, and load-result extension.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // state   | meaning
  // IDLE    | waiting for start
  // REQ     | mem_req asserted, waiting for mem_ready
  // WAIT_RD | load accepted, waiting for mem_rvalid
  // RESP    | one-cycle done pulse, fault/fault_code valid
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD, S_RESP} state_t;

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_is_load;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic [31:0]   r_mem_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [1:0]    r_code;
  logic [31:0]   r_load_data;
  logic [CW-1:0] r_cnt;

  logic          w_illegal;
  logic          w_misal;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  logic [CW-1:0] w_cnt_inc;
  logic          w_to_hit;

  always_comb begin
    w_illegal = 1'b0;
    if (is_load == is_store)
      w_illegal = 1'b1;
    else if (is_load)
      w_illegal = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
    else
      w_illegal = (funct3 >= 3'd3);
  end

  always_comb begin
    w_misal = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misal = addr[0];
      2'b10:   w_misal = |addr[1:0];
      default: w_misal = 1'b0;
    endcase
  end

  always_comb begin
    w_be    = 4'hF;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = store_data;
      end
    endcase
    if (!is_store) w_be = 4'h0;
  end

  assign w_byte = 8'(mem_rdata >> {r_off, 3'b000});
  assign w_half = 16'(mem_rdata >> {r_off[1], 4'b0000});

  always_comb begin
    w_ext = mem_rdata;
    case (r_f3)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_ext = {24'b0, w_byte};
      3'd5:    w_ext = {16'b0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_to_hit  = (TIMEOUT != 0) && (w_cnt_inc == TO_VAL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (w_illegal || w_misal) ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (mem_ready)     w_state_nxt = r_is_load ? S_WAIT_RD : S_RESP;
        else if (w_to_hit) w_state_nxt = S_RESP;
      end
      S_WAIT_RD: begin
        if (mem_rvalid || w_to_hit) w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_RESP);
    mem_req = (r_state == S_REQ);
    mem_we  = (r_state == S_REQ) && !r_is_load;
    fault   = (r_state == S_RESP) && (r_code != 2'd0);
  end

  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_be;
  assign mem_wdata  = r_wdata;
  assign fault_code = r_code;
  assign load_data  = r_load_data;

  // Timeout counter runs only while a memory transaction is outstanding.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state == S_REQ || r_state == S_WAIT_RD)
      r_cnt <= w_cnt_inc;
    else
      r_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_load   <= 1'b0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_mem_addr  <= 32'd0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_code      <= 2'd0;
      r_load_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_load  <= is_load;
            r_f3       <= funct3;
            r_off      <= addr[1:0];
            r_mem_addr <= {addr[31:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_code     <= w_illegal ? 2'd2 : (w_misal ? 2'd1 : 2'd0);
          end
        end
        S_REQ: begin
          if (!mem_ready && w_to_hit) r_code <= 2'd3;
        end
        S_WAIT_RD: begin
          if (mem_rvalid)    r_load_data <= w_ext;
          else if (w_to_hit) r_code      <= 2'd3;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases with literal
// expectations plus randomized accesses against a behavioural model.
module tb_lsu_mem_stage;
  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        rst, start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0, chk_zero = 0;

  logic        e_busy = 0, e_done = 0, e_req = 0, e_we = 0;
  logic [1:0]  e_code = 0;
  logic [31:0] e_ld = 0, e_addr = 0, e_wdata = 0;
  logic [3:0]  e_be = 0;

  int          s_dlat;
  logic        s_fault, s_we, s_anyreq;
  logic [1:0]  s_code;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  lsu_mem_stage #(.TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .fault_code(fault_code), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference rules expressed with plain arithmetic.
  function automatic logic [1:0] m_code(bit ld, bit st, logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = int'(f3 % 4);
    if (ld == st) return 2'd2;
    if (ld && (f3 == 3 || f3 >= 6)) return 2'd2;
    if (st && f3 >= 3) return 2'd2;
    if (sz == 1 && a % 2 != 0) return 2'd1;
    if (sz == 2 && a % 4 != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(bit st, logic [2:0] f3, logic [31:0] a);
    int nbytes;
    if (!st) return 4'h0;
    nbytes = 1 << (f3 % 4);
    return 4'(((1 << nbytes) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
    case (f3 % 4)
      0:       return 32'(sd[7:0]) * 32'h0101_0101;
      1:       return 32'(sd[15:0]) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int    bits;
    longint v;
    bits = 8 << (f3 % 4);
    if (bits >= 32) return rd;
    v = longint'((rd >> (8 * (a % 4)))) & ((64'd1 << bits) - 1);
    if (f3 < 4 && v >= longint'(64'd1 << (bits - 1))) v = v - longint'(64'd1 << bits);
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("load_data", load_data, e_ld);
      chk("fault", 32'(fault), 32'(e_done && e_code != 0));
      if (e_done) chk("fault_code", 32'(fault_code), 32'(e_code));
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (chk_zero) begin
        chk("zero_code", 32'(fault_code), 32'd0);
        chk("zero_addr", mem_addr, 32'd0);
        chk("zero_be", 32'(mem_be), 32'd0);
        chk("zero_wdata", mem_wdata, 32'd0);
        chk("zero_we", 32'(mem_we), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input bit b, input bit d, input bit r);
    e_busy = b; e_done = d; e_req = r;
  endtask

  task automatic noise();
    start      = ($urandom_range(0, 2) == 0);
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
    mem_ready  = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  task automatic observe(input int c);
    if (done && s_dlat < 0) begin
      s_dlat = c; s_fault = fault; s_code = fault_code;
    end
    s_anyreq = s_anyreq | mem_req;
  endtask

  // One access from an idle cycle; returns with the DUT idle again.
  task automatic do_acc(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int rdly, input int vdly, input logic [31:0] rd,
                        input bit rst_wait);
    logic [1:0] code;
    int n, m, ph, c;
    bit snapped;
    code = m_code(ld, st, f3, a);
    s_dlat = -1; s_anyreq = 0; snapped = 0;
    noise();
    is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
    tick();
    c = 1;
    e_we = st; e_addr = {a[31:2], 2'b00}; e_be = m_be(st, f3, a); e_wdata = m_wdata(f3, sd);
    e_code = code;
    ph = (code != 0) ? 2 : 0;
    n = 0; m = 0;
    while (ph != 3) begin
      if (ph == 0) begin
        ex(1, 0, 1);
        observe(c);
        if (!snapped) begin
          s_addr = mem_addr; s_be = mem_be; s_wdata = mem_wdata; s_we = mem_we; snapped = 1;
        end
        noise();
        mem_ready = (n == rdly);
        tick(); c++; n++;
        if (mem_ready) ph = st ? 2 : 1;
        else if (n == TO) begin ph = 2; e_code = 2'd3; end
      end else if (ph == 1) begin
        ex(1, 0, 0);
        observe(c);
        noise();
        if (rst_wait) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          ex(0, 0, 0); e_ld = 32'd0; e_code = 2'd0; chk_zero = 1;
          noise();
          start = 1'b0; mem_rvalid = 1'b1;
          tick();
          chk_zero = 0;
          start = 1'b0;
          return;
        end
        mem_rvalid = (m == vdly);
        mem_rdata  = mem_rvalid ? rd : $urandom;
        tick(); c++; n++; m++;
        if (mem_rvalid) begin ph = 2; e_ld = m_load(f3, a, rd); end
        else if (n == TO) begin ph = 2; e_code = 2'd3; end
      end else begin
        ex(1, 1, 0);
        observe(c);
        noise();
        start = 1'b1;
        tick(); c++;
        ph = 3;
      end
    end
    ex(0, 0, 0);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    chk_on = 1; chk_zero = 1;
    tick();
    rst = 1'b0;
    tick();
    chk_zero = 0;

    // SB to the top lane
    do_acc(0, 1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 0, 0);
    chk("sb_addr", s_addr, 32'h0000_1000);
    chk("sb_be", 32'(s_be), 32'h8);
    chk("sb_wdata", s_wdata, 32'hDDDD_DDDD);
    chk("sb_we", 32'(s_we), 32'd1);
    chk("sb_lat", 32'(s_dlat), 32'd2);
    chk("sb_fault", 32'(s_fault), 32'd0);

    // LH / LHU upper half
    do_acc(1, 0, 3'd1, 32'h0000_2002, 0, 0, 0, 32'h8001_1234, 0);
    chk("lh_data", load_data, 32'hFFFF_8001);
    chk("lh_lat", 32'(s_dlat), 32'd3);
    do_acc(1, 0, 3'd5, 32'h0000_2002, 0, 0, 0, 32'h8001_1234, 0);
    chk("lhu_data", load_data, 32'h0000_8001);

    // Faults detected at start
    do_acc(1, 0, 3'd2, 32'h0000_3001, 0, 0, 0, 0, 0);
    chk("lw_mis_lat", 32'(s_dlat), 32'd1);
    chk("lw_mis_fault", 32'(s_fault), 32'd1);
    chk("lw_mis_code", 32'(s_code), 32'd1);
    chk("lw_mis_noreq", 32'(s_anyreq), 32'd0);
    do_acc(1, 0, 3'd3, 32'h0000_3000, 0, 0, 0, 0, 0);
    chk("ld_f3_3_code", 32'(s_code), 32'd2);
    do_acc(1, 1, 3'd2, 32'h0000_3001, 0, 0, 0, 0, 0);
    chk("ld_st_code", 32'(s_code), 32'd2);
    chk("ld_st_noreq", 32'(s_anyreq), 32'd0);

    // Ready arrives on the last permitted cycle: completion beats timeout
    do_acc(0, 1, 3'd2, 32'h0000_4000, 32'h1234_5678, 5, 0, 0, 0);
    chk("slow_lat", 32'(s_dlat), 32'd7);
    chk("slow_code", 32'(s_code), 32'd0);

    // Timeout in REQ and in WAIT_RD; load_data must survive
    do_acc(0, 1, 3'd1, 32'h0000_5002, 32'hCAFE_BABE, 99, 0, 0, 0);
    chk("to_req_lat", 32'(s_dlat), 32'd7);
    chk("to_req_code", 32'(s_code), 32'd3);
    do_acc(1, 0, 3'd2, 32'h0000_5004, 0, 0, 99, 32'h5555_AAAA, 0);
    chk("to_rd_code", 32'(s_code), 32'd3);
    chk("to_rd_keep", load_data, 32'h0000_8001);

    // Reset in WAIT_RD, then a clean LB
    do_acc(1, 0, 3'd2, 32'h0000_6000, 0, 0, 3, 32'h1111_2222, 1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    do_acc(1, 0, 3'd0, 32'h0000_7001, 0, 0, 0, 32'h0000_8000, 0);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_lat", 32'(s_dlat), 32'd3);

    for (int i = 0; i < 400; i++) begin
      int sel;
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      ld = (sel < 5) || (sel == 8);
      st = (sel >= 5 && sel < 8) || (sel == 8);
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else if (ld) begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3) f3 = 3'd5;
        end
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_acc(ld, st, f3, a, $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom, 0);
    end

    tick(); tick();
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
